mdiv_operand_loader: RTL
========================

# mdiv_operand_loader

Upstream front end of the 256-bit modular division/inversion engine. Accepts operands as a stream of 32-bit words over a valid/ready handshake, in the order p, y, x. In inversion mode x is instead forced to 1. It checks the operands for legality, holds them stable on 256-bit buses and issues a one-cycle `core_minv_en` start pulse once the core is idle. It then tracks the core's `has_done` until the job completes and frees the input for the next job.

## Interface
- W, 32, word width in bits
- N, 8, words per operand (operand width W*N = 256)
- clk  in  1  clock
- rst  in  1  reset; rst, synchronous, active-high; clock clk
- in_valid  in  1  input word valid
- in_ready  out  1  loader accepts a word this cycle
- in_data  in  W  operand word, least-significant word first
- in_mode  in  1  sampled with the first word of a job: 0 = division x/y mod p, 1 = inversion 1/y mod p
- core_has_done  in  1  core idle indicator (high only in core idle state)
- core_minv_en  out  1  one-cycle start pulse to core
- op_p, op_y, op_x  out  W*N  operand buses, stable from start pulse until job done
- busy  out  1  high in every state except IDLE
- job_done  out  1  one-cycle pulse when the core returns to idle
- err  out  1  one-cycle pulse when an operand set is rejected
- err_code  out  2  held from err until next job start: 0 none, 1 p even, 2 p==1, 3 y==0

## Operation
- States: IDLE, LOAD_P, LOAD_Y, LOAD_X, CHECK, WAIT_CORE, START, RUN_LO, RUN_HI.
- Accept rule: a word is accepted when in_valid && in_ready. in_ready is 1 in IDLE, LOAD_P, LOAD_Y and LOAD_X, 0 elsewhere and while rst is high.
- IDLE: an accepted word is p word 0. It latches mode, clears err_code and wcnt=1, then goes to LOAD_P.
- LOAD_P/LOAD_Y/LOAD_X: accepted word k is written to bits [W*k+W-1:W*k] of the operand. Word counter wcnt (3 bits) increments. Accepting word N-1 wraps wcnt to 0 and advances. LOAD_Y goes to LOAD_X in mode 0, or to CHECK in mode 1.
- Mode 1 sets op_x = 1 (word 0 = 1, other words 0) on the transition into CHECK.
- Flags accumulate per beat:
  - p_odd = bit 0 of p word 0.
  - p_hi_zero = OR-reduction of p words 1..N-1 is 0.
  - y_nz = OR of all y words.
- CHECK (1 cycle):
  - Error priority is p even, then p==1 (p word 0==1 && p_hi_zero), then y==0.
  - On error: pulse err, set err_code, go to IDLE. Operands are retained and core_minv_en is never issued.
  - Otherwise go to START if core_has_done, else to WAIT_CORE.
- WAIT_CORE: go to START when core_has_done.
- START: core_minv_en=1 for exactly one cycle, then RUN_LO.
- RUN_LO: wait for core_has_done==0, then RUN_HI. The core drops has_done one cycle after the start pulse.
- RUN_HI: wait for core_has_done==1. Then pulse job_done and go to IDLE.

## Timing
- Reset values:
  - state IDLE, wcnt 0, op_p/op_y/op_x 0, flags 0.
  - Outputs: core_minv_en 0, busy 0, job_done 0, err 0, err_code 0.
- Minimum load time: 24 cycles in mode 0, 16 in mode 1 (one word per cycle with in_valid held high).
- If the last word is accepted at edge t: CHECK occupies cycle t+1. START (core_minv_en high) occupies cycle t+2 if core_has_done is high at t+1; otherwise it occupies the cycle after has_done is seen high.
- job_done is asserted the cycle after core_has_done is seen high in RUN_HI. in_ready rises in that same cycle.
- in_valid low mid-operand: wcnt and state hold, with no gap penalty.
- Reset mid-operation: all state is cleared on the next edge. A pending start pulse is cancelled. The core shares rst, so no orphaned job remains.
- err and core_minv_en are never asserted in the same job.

## Structure
- Package mdiv_pkg: W, N, state enum, err_code constants (ERR_NONE, ERR_P_EVEN, ERR_P_ONE, ERR_Y_ZERO).
- One sub-module mdiv_opreg is instantiated three times. It provides word-indexed write of a W*N register with running zero/one detection.
- FSM and flag logic live in the top level.

## Test plan
- Mode 0, p = 2^255-19, y = 3, x = 5, streamed back-to-back with core_has_done=1 → core_minv_en pulses at cycle t+2 after the 24th beat, and op buses hold the values exactly.
- Mode 1, p = 2^255-19, y = 7 → 16 beats accepted, op_x == 1, and one start pulse.
- Error cases, each with y=3:
  - p = 0x...10 → err pulse, err_code=1, no start pulse.
  - p = 1 → err_code=2.
  - p odd with y = 0 → err_code=3.
- Start while core busy: hold core_has_done=0 for 10 cycles after CHECK → the loader stays in WAIT_CORE, then pulses start the cycle after has_done rises.
- Random in_valid gaps, plus has_done low for 500 cycles, then high → job_done is one pulse and in_ready stays 0 throughout RUN.
- rst asserted mid LOAD_Y → next cycle: IDLE, all ops 0, wcnt 0, and in_ready is 1 after rst is released.

Source files
------------

// File: rtl/mdiv_pkg.sv
// rtl/mdiv_pkg.sv - shared widths, FSM states and error codes for the operand loader
package mdiv_pkg;

    localparam int W      = 32;
    localparam int N      = 8;
    localparam int WCNT_W = 3;

    typedef enum logic [3:0] {
        IDLE,
        LOAD_P,
        LOAD_Y,
        LOAD_X,
        CHECK,
        WAIT_CORE,
        START,
        RUN_LO,
        RUN_HI
    } state_t;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_P_EVEN = 2'd1;
    localparam logic [1:0] ERR_P_ONE  = 2'd2;
    localparam logic [1:0] ERR_Y_ZERO = 2'd3;

endpackage

// File: rtl/mdiv_opreg.sv
// rtl/mdiv_opreg.sv - word-indexed W*N operand register with per-beat zero/one detection
module mdiv_opreg
    import mdiv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [WCNT_W-1:0] wr_idx,
    input  logic [W-1:0]      wr_data,
    input  logic              set_one,
    output logic [W*N-1:0]    value,
    output logic              wr_nz,
    output logic              wr_one
);

    localparam logic [W*N-1:0] ONE = (W*N)'(1);

    logic [W*N-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (set_one) begin
            value_d = ONE;
        end else if (wr_en) begin
            value_d[int'(wr_idx)*W +: W] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    // Flags describe the word being written this beat; the caller accumulates them.
    assign wr_nz  = |wr_data;
    assign wr_one = (wr_data == W'(1));
    assign value  = value_q;

endmodule

// File: rtl/mdiv_operand_loader.sv
// rtl/mdiv_operand_loader.sv - streams p/y/x operands in, checks legality and launches the core
module mdiv_operand_loader
    import mdiv_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    input  logic           in_mode,
    input  logic           core_has_done,
    output logic           core_minv_en,
    output logic [W*N-1:0] op_p,
    output logic [W*N-1:0] op_y,
    output logic [W*N-1:0] op_x,
    output logic           busy,
    output logic           job_done,
    output logic           err,
    output logic [1:0]     err_code
);

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              mode_q, mode_d;
    logic              p_odd_q, p_odd_d;
    logic              p_lo_one_q, p_lo_one_d;
    logic              p_hi_zero_q, p_hi_zero_d;
    logic              y_nz_q, y_nz_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              job_done_q, job_done_d;

    logic       accept, last_word;
    logic       wr_p, wr_y, wr_x, set_x_one;
    logic       p_nz, p_one, y_nz_w, y_one, x_nz, x_one;
    logic [1:0] chk_code;
    logic       unused_flags;

    assign in_ready  = !rst && (state_q inside {IDLE, LOAD_P, LOAD_Y, LOAD_X});
    assign accept    = in_valid && in_ready;
    assign last_word = (wcnt_q == WCNT_W'(N - 1));

    always_comb begin
        chk_code = ERR_NONE;
        if (!p_odd_q) begin
            chk_code = ERR_P_EVEN;
        end else if (p_lo_one_q && p_hi_zero_q) begin
            chk_code = ERR_P_ONE;
        end else if (!y_nz_q) begin
            chk_code = ERR_Y_ZERO;
        end
    end

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        mode_d      = mode_q;
        p_odd_d     = p_odd_q;
        p_lo_one_d  = p_lo_one_q;
        p_hi_zero_d = p_hi_zero_q;
        y_nz_d      = y_nz_q;
        err_code_d  = err_code_q;
        job_done_d  = 1'b0;
        wr_p        = 1'b0;
        wr_y        = 1'b0;
        wr_x        = 1'b0;
        set_x_one   = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    wr_p        = 1'b1;
                    mode_d      = in_mode;
                    err_code_d  = ERR_NONE;
                    wcnt_d      = WCNT_W'(1);
                    p_odd_d     = in_data[0];
                    p_lo_one_d  = p_one;
                    p_hi_zero_d = 1'b1;
                    y_nz_d      = 1'b0;
                    state_d     = LOAD_P;
                end
            end
            LOAD_P: begin
                if (accept) begin
                    wr_p        = 1'b1;
                    p_hi_zero_d = p_hi_zero_q && !p_nz;
                    wcnt_d      = wcnt_q + WCNT_W'(1);
                    if (last_word) state_d = LOAD_Y;
                end
            end
            LOAD_Y: begin
                if (accept) begin
                    wr_y   = 1'b1;
                    y_nz_d = y_nz_q || y_nz_w;
                    wcnt_d = wcnt_q + WCNT_W'(1);
                    if (last_word) begin
                        // Inversion skips the x stream and uses x = 1.
                        if (mode_q) begin
                            set_x_one = 1'b1;
                            state_d   = CHECK;
                        end else begin
                            state_d = LOAD_X;
                        end
                    end
                end
            end
            LOAD_X: begin
                if (accept) begin
                    wr_x   = 1'b1;
                    wcnt_d = wcnt_q + WCNT_W'(1);
                    if (last_word) state_d = CHECK;
                end
            end
            CHECK: begin
                if (chk_code != ERR_NONE) begin
                    err_code_d = chk_code;
                    state_d    = IDLE;
                end else if (core_has_done) begin
                    state_d = START;
                end else begin
                    state_d = WAIT_CORE;
                end
            end
            WAIT_CORE: begin
                if (core_has_done) state_d = START;
            end
            START: begin
                state_d = RUN_LO;
            end
            RUN_LO: begin
                if (!core_has_done) state_d = RUN_HI;
            end
            RUN_HI: begin
                if (core_has_done) begin
                    job_done_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            mode_q      <= 1'b0;
            p_odd_q     <= 1'b0;
            p_lo_one_q  <= 1'b0;
            p_hi_zero_q <= 1'b0;
            y_nz_q      <= 1'b0;
            err_code_q  <= ERR_NONE;
            job_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            mode_q      <= mode_d;
            p_odd_q     <= p_odd_d;
            p_lo_one_q  <= p_lo_one_d;
            p_hi_zero_q <= p_hi_zero_d;
            y_nz_q      <= y_nz_d;
            err_code_q  <= err_code_d;
            job_done_q  <= job_done_d;
        end
    end

    mdiv_opreg u_op_p (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_p),
        .wr_idx  (wcnt_q),
        .wr_data (in_data),
        .set_one (1'b0),
        .value   (op_p),
        .wr_nz   (p_nz),
        .wr_one  (p_one)
    );

    mdiv_opreg u_op_y (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_y),
        .wr_idx  (wcnt_q),
        .wr_data (in_data),
        .set_one (1'b0),
        .value   (op_y),
        .wr_nz   (y_nz_w),
        .wr_one  (y_one)
    );

    mdiv_opreg u_op_x (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_x),
        .wr_idx  (wcnt_q),
        .wr_data (in_data),
        .set_one (set_x_one),
        .value   (op_x),
        .wr_nz   (x_nz),
        .wr_one  (x_one)
    );

    assign unused_flags = ^{y_one, x_nz, x_one};

    assign core_minv_en = (state_q == START);
    assign busy         = (state_q != IDLE);
    assign job_done     = job_done_q;
    assign err          = (state_q == CHECK) && (chk_code != ERR_NONE);
    assign err_code     = err ? chk_code : err_code_q;

endmodule
